// File: rtl/reaction_game_ctrl_pkg.sv
// Shared types and helpers for the reaction game round sequencer:
// state codes, difficulty-to-level priority and timer sizing.
package reaction_game_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RUN        = 3'd1,
        ST_HIT_FLASH  = 3'd2,
        ST_MISS_FLASH = 3'd3,
        ST_OVER       = 3'd4
    } game_state_e;

    localparam int DIFF_W            = 7;
    localparam int STEP_BASE_DEFAULT = 4;
    // Wide enough for the slowest step period, STEP_BASE*7.
    localparam int PERIOD_W          = $clog2(STEP_BASE_DEFAULT * 7 + 1);

    // Level is one plus the index of the highest set switch; no switch -> level 1.
    function automatic logic [2:0] level_of(input logic [DIFF_W-1:0] diff);
        logic [2:0] lvl;
        lvl = 3'd1;
        for (int i = 0; i < DIFF_W; i++) begin
            if (diff[i]) begin
                lvl = 3'(i + 1);
            end
        end
        return lvl;
    endfunction

    // Counter width that holds both the longest step period and the flash dwell.
    function automatic int timer_width(input int step_base, input int flash_cycles);
        int span;
        span = step_base * 7;
        if (flash_cycles > span) begin
            span = flash_cycles;
        end
        return (span < 2) ? 1 : $clog2(span);
    endfunction

endpackage

// File: rtl/reaction_game_ctrl_if.sv
// Game-facing signal bundle: button/switch inputs and lamp/score/status outputs.
// slave is the controller side, master is whoever drives the buttons.
interface reaction_game_ctrl_if;
    import reaction_game_ctrl_pkg::*;

    logic              start_i;
    logic              hit_i;
    logic [DIFF_W-1:0] diff_i;
    logic [2:0]        led_pos_o;
    logic              led_en_o;
    logic [3:0]        score_o;
    logic [1:0]        lives_o;
    logic [2:0]        state_o;
    logic              game_over_o;

    modport slave (
        input  start_i, hit_i, diff_i,
        output led_pos_o, led_en_o, score_o, lives_o, state_o, game_over_o
    );

    modport master (
        output start_i, hit_i, diff_i,
        input  led_pos_o, led_en_o, score_o, lives_o, state_o, game_over_o
    );
endinterface

// File: rtl/reaction_game_ctrl_step_timer.sv
// Loadable down-counter with clear; expire_o strobes while enabled at zero.
// One instance times both lamp steps and flash dwells.
module reaction_game_ctrl_step_timer #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             expire_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Loading N-1 therefore yields an expiry on the N-th enabled cycle.
    assign expire_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/reaction_game_ctrl.sv
// Round sequencer for the sliding-LED reaction game: lamp stepping, hit/miss
// judging, scoring and lives, with all outputs registered.
module reaction_game_ctrl
    import reaction_game_ctrl_pkg::*;
#(
    parameter int STEP_BASE    = 4,
    parameter int N_LEDS       = 7,
    parameter int TARGET_POS   = 0,
    parameter int SCORE_MAX    = 9,
    parameter int LIVES        = 3,
    parameter int FLASH_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    reaction_game_ctrl_if.slave   bus
);

    localparam int         CNT_W     = timer_width(STEP_BASE, FLASH_CYCLES);
    localparam logic [2:0] LAST_POS  = 3'(N_LEDS - 1);
    localparam logic [2:0] TARGET    = 3'(TARGET_POS);
    localparam logic [3:0] SCORE_TOP = 4'(SCORE_MAX);
    localparam logic [1:0] LIVES_INI = 2'(LIVES);
    localparam logic [CNT_W-1:0] FLASH_M1 = CNT_W'(FLASH_CYCLES - 1);

    function automatic logic [CNT_W-1:0] period_m1_of(input logic [2:0] lvl);
        return CNT_W'(STEP_BASE * (8 - int'(lvl)) - 1);
    endfunction

    game_state_e state_q, state_d;
    logic [2:0]  led_pos_q, led_pos_d;
    logic [3:0]  score_q, score_d;
    logic [1:0]  lives_q, lives_d;
    logic [2:0]  level_q, level_d;
    logic        led_en_q, led_en_d;
    logic        game_over_q, game_over_d;

    logic             tmr_clear;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_load_val;
    logic             tmr_en;
    logic             tmr_expire;

    reaction_game_ctrl_step_timer #(
        .WIDTH (CNT_W)
    ) u_step_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (tmr_clear),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .en_i       (tmr_en),
        .expire_o   (tmr_expire)
    );

    always_comb begin
        state_d      = state_q;
        led_pos_d    = led_pos_q;
        score_d      = score_q;
        lives_d      = lives_q;
        level_d      = level_q;
        tmr_clear    = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = period_m1_of(level_q);
        tmr_en       = 1'b0;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                tmr_clear = 1'b1;
                // A coincident hit is simply not looked at here, so start wins.
                if (bus.start_i) begin
                    level_d      = level_of(bus.diff_i);
                    state_d      = ST_RUN;
                    score_d      = '0;
                    lives_d      = LIVES_INI;
                    led_pos_d    = LAST_POS;
                    tmr_clear    = 1'b0;
                    tmr_load     = 1'b1;
                    tmr_load_val = period_m1_of(level_d);
                end
            end

            ST_RUN: begin
                tmr_en = 1'b1;
                if (bus.hit_i) begin
                    // Judged on the lamp currently shown, even if the step expires now.
                    tmr_load     = 1'b1;
                    tmr_load_val = FLASH_M1;
                    if (led_pos_q == TARGET) begin
                        state_d = ST_HIT_FLASH;
                        if (score_q != SCORE_TOP) begin
                            score_d = score_q + 4'd1;
                        end
                    end else begin
                        state_d = ST_MISS_FLASH;
                        lives_d = lives_q - 2'd1;
                    end
                end else if (tmr_expire) begin
                    tmr_load = 1'b1;
                    if (led_pos_q == TARGET) begin
                        tmr_load_val = FLASH_M1;
                        state_d      = ST_MISS_FLASH;
                        lives_d      = lives_q - 2'd1;
                    end else begin
                        led_pos_d = (led_pos_q == 3'd0) ? LAST_POS : led_pos_q - 3'd1;
                    end
                end
            end

            ST_HIT_FLASH, ST_MISS_FLASH: begin
                tmr_en = 1'b1;
                if (tmr_expire) begin
                    if (lives_q == 2'd0) begin
                        state_d = ST_OVER;
                    end else begin
                        state_d   = ST_RUN;
                        led_pos_d = LAST_POS;
                        tmr_load  = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        led_en_d    = (state_d == ST_RUN) || (state_d == ST_HIT_FLASH);
        game_over_d = (state_d == ST_OVER);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            led_pos_q   <= 3'd0;
            score_q     <= 4'd0;
            lives_q     <= LIVES_INI;
            level_q     <= 3'd1;
            led_en_q    <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            led_pos_q   <= led_pos_d;
            score_q     <= score_d;
            lives_q     <= lives_d;
            level_q     <= level_d;
            led_en_q    <= led_en_d;
            game_over_q <= game_over_d;
        end
    end

    assign bus.led_pos_o   = led_pos_q;
    assign bus.led_en_o    = led_en_q;
    assign bus.score_o     = score_q;
    assign bus.lives_o     = lives_q;
    assign bus.state_o     = state_q;
    assign bus.game_over_o = game_over_q;

endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Bench for reaction_game_ctrl: scripted scenarios with literal expectations,
// then random button traffic, all checked every cycle against a timeline model.
module tb_reaction_game_ctrl;

    localparam int STEP_BASE    = 4;
    localparam int N_LEDS       = 7;
    localparam int SCORE_MAX    = 9;
    localparam int LIVES        = 3;
    localparam int FLASH_CYCLES = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic chk_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    reaction_game_ctrl_if bus ();

    reaction_game_ctrl #(
        .STEP_BASE    (STEP_BASE),
        .N_LEDS       (N_LEDS),
        .TARGET_POS   (0),
        .SCORE_MAX    (SCORE_MAX),
        .LIVES        (LIVES),
        .FLASH_CYCLES (FLASH_CYCLES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: mode 0 idle, 1 run, 2 hit flash, 3 miss flash, 4 over.
    // In run the lamp is derived from cycles elapsed since the round began.
    typedef struct packed {
        int mode;
        int score;
        int lives;
        int period;
        int elapsed;
        int flash;
        int pos;
    } model_t;

    model_t m;

    function automatic int level_from(input logic [6:0] d);
        int n;
        logic [6:0] v;
        n = 0;
        v = d;
        while (v != 7'd0) begin
            n++;
            v = v >> 1;
        end
        return (n == 0) ? 1 : n;
    endfunction

    function automatic model_t model_reset();
        model_t r;
        r.mode = 0; r.score = 0; r.lives = LIVES; r.period = 28;
        r.elapsed = 0; r.flash = 0; r.pos = 0;
        return r;
    endfunction

    function automatic int model_pos(input model_t s);
        return (s.mode == 1) ? (N_LEDS - 1) - s.elapsed / s.period : s.pos;
    endfunction

    function automatic model_t model_next(input model_t s, input logic st,
                                          input logic ht, input logic [6:0] df);
        model_t n;
        int cur;
        bit expire;
        n = s;
        case (s.mode)
            0, 4: begin
                if (st) begin
                    n.mode = 1; n.period = STEP_BASE * (8 - level_from(df));
                    n.elapsed = 0; n.score = 0; n.lives = LIVES; n.pos = N_LEDS - 1;
                end
            end
            1: begin
                cur = model_pos(s);
                expire = ((s.elapsed + 1) % s.period) == 0;
                if (ht) begin
                    n.pos = cur; n.flash = 0;
                    if (cur == 0) begin
                        n.mode = 2;
                        n.score = (s.score + 1 > SCORE_MAX) ? SCORE_MAX : s.score + 1;
                    end else begin
                        n.mode = 3; n.lives = s.lives - 1;
                    end
                end else if (expire && cur == 0) begin
                    n.pos = 0; n.flash = 0; n.mode = 3; n.lives = s.lives - 1;
                end else begin
                    n.elapsed = s.elapsed + 1;
                end
            end
            default: begin
                n.flash = s.flash + 1;
                if (n.flash == FLASH_CYCLES) begin
                    if (s.lives == 0) begin
                        n.mode = 4;
                    end else begin
                        n.mode = 1; n.elapsed = 0; n.pos = N_LEDS - 1;
                    end
                end
            end
        endcase
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= model_reset();
        else        m <= model_next(m, bus.start_i, bus.hit_i, bus.diff_i);
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("state",     bus.state_o,     m.mode);
            cmp("led_pos",   bus.led_pos_o,   model_pos(m));
            cmp("led_en",    bus.led_en_o,    (m.mode == 1 || m.mode == 2) ? 1 : 0);
            cmp("score",     bus.score_o,     m.score);
            cmp("lives",     bus.lives_o,     m.lives);
            cmp("game_over", bus.game_over_o, (m.mode == 4) ? 1 : 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input logic [6:0] d);
        bus.diff_i = d; bus.start_i = 1'b1;
        tick(1);
        bus.start_i = 1'b0;
    endtask

    task automatic do_hit();
        bus.hit_i = 1'b1;
        tick(1);
        bus.hit_i = 1'b0;
    endtask

    task automatic wait_pos(input int p, input int limit);
        int n;
        n = 0;
        while (!(m.mode == 1 && model_pos(m) == p) && n < limit) begin
            tick(1);
            n++;
        end
        checks++;
        if (n >= limit) begin
            errors++;
            $display("FAIL wait_pos: lamp %0d not reached in %0d cycles, got %0d", p, limit, bus.led_pos_o);
        end
    endtask

    initial begin
        bus.start_i = 1'b0; bus.hit_i = 1'b0; bus.diff_i = 7'd0;
        tick(2);
        chk_en = 1'b1;
        cmp("rst_state", bus.state_o, 0);
        cmp("rst_lives", bus.lives_o, 3);
        cmp("rst_led_en", bus.led_en_o, 0);
        rst_n = 1'b1;
        tick(1);

        // Level 3 -> period 20
        do_start(7'b0000100);
        cmp("start_state", bus.state_o, 1);
        cmp("start_pos", bus.led_pos_o, 6);
        tick(20);
        cmp("step_pos5", bus.led_pos_o, 5);
        wait_pos(0, 200);
        tick(3);
        do_hit();
        cmp("hit_state", bus.state_o, 2);
        cmp("hit_score", bus.score_o, 1);
        tick(7);
        cmp("flash_hold", bus.state_o, 2);
        tick(1);
        cmp("flash_exit", bus.state_o, 1);
        cmp("flash_pos", bus.led_pos_o, 6);

        // Three wrong-lamp hits drain the lives; a hit during the flash is ignored
        for (int k = 1; k <= 3; k++) begin
            wait_pos(3, 200);
            do_hit();
            cmp("miss_state", bus.state_o, 3);
            cmp("miss_lives", bus.lives_o, 3 - k);
            tick(2);
            do_hit();
            tick(5);
            cmp("after_miss_state", bus.state_o, (k < 3) ? 1 : 4);
        end
        cmp("over_flag", bus.game_over_o, 1);
        cmp("over_score", bus.score_o, 1);

        // start and hit together in OVER: start wins; level 7 -> period 4
        bus.diff_i = 7'h40; bus.start_i = 1'b1; bus.hit_i = 1'b1;
        tick(1);
        bus.start_i = 1'b0; bus.hit_i = 1'b0; bus.diff_i = 7'd0;
        cmp("restart_state", bus.state_o, 1);
        cmp("restart_score", bus.score_o, 0);
        cmp("restart_lives", bus.lives_o, 3);

        // Hit landing in the expiry cycle at lamp 0 scores
        wait_pos(0, 100);
        tick(3);
        do_hit();
        cmp("coinc_state", bus.state_o, 2);
        cmp("coinc_score", bus.score_o, 1);
        cmp("coinc_lives", bus.lives_o, 3);
        tick(8);

        // Lamp escapes past the target
        wait_pos(0, 100);
        tick(4);
        cmp("escape_state", bus.state_o, 3);
        cmp("escape_lives", bus.lives_o, 2);
        tick(8);

        // Eleven more target hits: score saturates at 9
        for (int k = 0; k < 11; k++) begin
            wait_pos(0, 100);
            do_hit();
            cmp("sat_score", bus.score_o, (k + 2 > 9) ? 9 : k + 2);
            tick(8);
        end
        cmp("sat_lives", bus.lives_o, 2);

        for (int k = 0; k < 2; k++) begin
            wait_pos(0, 100);
            tick(4);
            cmp("end_lives", bus.lives_o, 1 - k);
            tick(8);
        end
        cmp("end_over", bus.game_over_o, 1);
        cmp("end_score", bus.score_o, 9);

        // Level 1 (diff 0) -> period 28; async reset mid-run, no clock edge
        do_start(7'd0);
        tick(30);
        cmp("lvl1_pos", bus.led_pos_o, 5);
        rst_n = 1'b0;
        #2;
        cmp("arst_state", bus.state_o, 0);
        cmp("arst_score", bus.score_o, 0);
        cmp("arst_lives", bus.lives_o, 3);
        cmp("arst_led_en", bus.led_en_o, 0);
        cmp("arst_pos", bus.led_pos_o, 0);
        tick(1);
        rst_n = 1'b1;
        tick(2);

        for (int c = 0; c < 4000; c++) begin
            bus.start_i = ($urandom_range(0, 99) < 3);
            bus.hit_i   = ($urandom_range(0, 99) < 8);
            bus.diff_i  = 7'($urandom);
            rst_n       = ($urandom_range(0, 999) != 0);
            tick(1);
        end
        rst_n = 1'b1;
        bus.start_i = 1'b0; bus.hit_i = 1'b0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
